// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and state encoding for the servo PWM block
package servo_pkg;
    localparam int ANGLE_MAX       = 180;
    localparam int DEF_FRAME_TICKS = 1_000_000;
    localparam int DEF_MIN_TICKS   = 25_000;
    localparam int DEF_DEG_TICKS   = 556;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN
    } state_e;
endpackage

// File: rtl/angle_to_ticks.sv
// rtl/angle_to_ticks.sv - clamp an angle to 0..180 and convert it to a pulse width in ticks
module angle_to_ticks
    import servo_pkg::*;
#(
    parameter int CW        = 20,
    parameter int MIN_TICKS = DEF_MIN_TICKS,
    parameter int DEG_TICKS = DEF_DEG_TICKS
) (
    input  logic [7:0]    angle,
    output logic [CW-1:0] ticks
);
    logic [7:0] a_clamped;

    always_comb begin
        a_clamped = (angle > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : angle;
        ticks     = CW'(MIN_TICKS) + CW'(a_clamped) * CW'(DEG_TICKS);
    end
endmodule

// File: rtl/servo_pwm_out.sv
// rtl/servo_pwm_out.sv - four-channel servo PWM with per-frame angle snapshot and
// double-buffered pulse thresholds computed by one shared converter
module servo_pwm_out
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int MIN_TICKS   = DEF_MIN_TICKS,
    parameter int DEG_TICKS   = DEF_DEG_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    input  logic [7:0] angle3,
    input  logic [7:0] angle4,
    output logic       pwm1,
    output logic       pwm2,
    output logic       pwm3,
    output logic       pwm4,
    output logic       frame_start,
    output logic       active
);
    localparam int            CW       = $clog2(FRAME_TICKS);
    localparam logic [CW-1:0] CNT_SNAP = CW'(FRAME_TICKS - 6);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TICKS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]    ch_q, ch_d;
    logic          first_q, first_d;
    logic [7:0]    snap_q [4];
    logic [7:0]    snap_d [4];
    logic [CW-1:0] thr_next_q [4];
    logic [CW-1:0] thr_next_d [4];
    logic [CW-1:0] thr_active_q [4];
    logic [CW-1:0] thr_active_d [4];
    logic [3:0]    pwm_q, pwm_d;
    logic          frame_start_q, frame_start_d;
    logic          active_q, active_d;
    logic          running;
    logic [CW-1:0] calc_ticks;

    angle_to_ticks #(
        .CW       (CW),
        .MIN_TICKS(MIN_TICKS),
        .DEG_TICKS(DEG_TICKS)
    ) u_angle_to_ticks (
        .angle(snap_q[ch_q]),
        .ticks(calc_ticks)
    );

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        ch_d         = ch_q;
        first_d      = first_q;
        snap_d       = snap_q;
        thr_next_d   = thr_next_q;
        thr_active_d = thr_active_q;
        running      = 1'b0;

        case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                if (en) begin
                    snap_d  = '{angle1, angle2, angle3, angle4};
                    first_d = 1'b1;
                    ch_d    = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // The start-up CALC has no frame behind it, so the counter waits at 0.
                running             = !first_q;
                thr_next_d[ch_q]    = calc_ticks;
                ch_d                = ch_q + 2'd1;
                frame_cnt_d         = first_q ? '0 : frame_cnt_q + 1'b1;
                if (ch_q == 2'd3) begin
                    state_d = RUN;
                    if (first_q) begin
                        thr_active_d = thr_next_d;
                        first_d      = 1'b0;
                    end
                end
            end
            RUN: begin
                running     = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_q == CNT_SNAP) begin
                    snap_d  = '{angle1, angle2, angle3, angle4};
                    ch_d    = 2'd0;
                    state_d = CALC;
                end else if (frame_cnt_q == CNT_LAST) begin
                    frame_cnt_d  = '0;
                    thr_active_d = thr_next_q;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = running && (state_d != IDLE) && (frame_cnt_q < thr_active_q[i]);
        end
        frame_start_d = running && (frame_cnt_q == '0);
        active_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            ch_q          <= '0;
            first_q       <= 1'b0;
            snap_q        <= '{default: '0};
            thr_next_q    <= '{default: '0};
            thr_active_q  <= '{default: '0};
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            ch_q          <= ch_d;
            first_q       <= first_d;
            snap_q        <= snap_d;
            thr_next_q    <= thr_next_d;
            thr_active_q  <= thr_active_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
        end
    end

    assign pwm1        = pwm_q[0];
    assign pwm2        = pwm_q[1];
    assign pwm3        = pwm_q[2];
    assign pwm4        = pwm_q[3];
    assign frame_start = frame_start_q;
    assign active      = active_q;
endmodule
